ctrl_interrupciones: RTL and testbench

//  Interrupt controller sitting directly upstream of the return-address stack in the single-cycle CPU.

---
 rtl/ctrl_interrupciones_pkg.sv | 11 +
 rtl/ctrl_interrupciones_sincro.sv | 33 +++
 rtl/ctrl_interrupciones.sv | 147 ++++++++++++++
 tb/tb_ctrl_interrupciones.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_interrupciones_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding and default vector base.
package ctrl_interrupciones_pkg;

   typedef enum logic {
      IDLE     = 1'b0,
      SERVICIO = 1'b1
   } estado_t;

   localparam logic [9:0] VEC_BASE_DEF = 10'h3F0;

endpackage

// File: rtl/ctrl_interrupciones_sincro.sv
// Two-flop synchroniser for the raw interrupt pins followed by a rising-edge detector.
// A pin edge shows up on flanco_o during the cycle after the second flop captures it,
// so the pending register that consumes it is set on the third clock edge.
module sincro_flanco #(
   parameter int N_INT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_INT-1:0] irq_i,
   output logic [N_INT-1:0] flanco_o
);

   logic [N_INT-1:0] meta_q;
   logic [N_INT-1:0] sinc_q;
   logic [N_INT-1:0] prev_q;

   // Shift the pin levels through the synchroniser and keep last cycle's level
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q <= '0;
         sinc_q <= '0;
         prev_q <= '0;
      end else begin
         // NOTE: non-blocking so each stage captures its neighbour's pre-edge value
         meta_q <= irq_i;
         sinc_q <= meta_q;
         prev_q <= sinc_q;
      end
   end

   assign flanco_o = sinc_q & ~prev_q;

endmodule

// File: rtl/ctrl_interrupciones.sv
// Interrupt controller in front of the return-address stack: latches requests,
// vectors the PC to the highest-priority one, saves/restores the PC on the stack
// and merges its own stack traffic with CALL/RET from the control unit.
module ctrl_interrupciones
   import ctrl_interrupciones_pkg::*;
#(
   parameter int               N_INT    = 4,
   parameter int               WIDTH    = 10,
   parameter logic [WIDTH-1:0] VEC_BASE = WIDTH'(VEC_BASE_DEF),
   parameter int               DEPTH    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_INT-1:0] irq,
   input  logic             ie_set,
   input  logic             ie_clr,
   input  logic             mask_we,
   input  logic [N_INT-1:0] mask_in,
   input  logic             reti,
   input  logic             cpu_push,
   input  logic             cpu_pop,
   input  logic [WIDTH-1:0] cpu_dato,
   input  logic [WIDTH-1:0] pc_actual,
   output logic             take,
   output logic [WIDTH-1:0] vector,
   output logic             pop_ret,
   output logic             push,
   output logic             pop,
   output logic             weSP,
   output logic [WIDTH-1:0] entrada,
   output logic [N_INT-1:0] pending,
   output logic             en_servicio,
   output logic             err_pila
);

   localparam int               SEL_W   = (N_INT > 1) ? $clog2(N_INT) : 1;
   localparam int               OCC_W   = $clog2(DEPTH + 1);
   localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

   estado_t          estado_q, estado_d;
   logic             ie_q, ie_d;
   logic [N_INT-1:0] mask_q, mask_d;
   logic [N_INT-1:0] pending_q, pending_d;
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             err_q, err_d;

   logic [N_INT-1:0] flanco, req, clr;
   logic [SEL_W-1:0] sel;
   logic             hay_req, lleno, vacio, instr, conflicto;
   logic             take_int, int_bloq;
   logic             push_cpu, push_bloq, pop_cpu, pop_bloq;
   logic             reti_sol, reti_ok, reti_bloq;

   sincro_flanco #(.N_INT(N_INT)) u_sincro (
      .clk      (clk),
      .reset    (reset),
      .irq_i    (irq),
      .flanco_o (flanco)
   );

   assign req     = pending_q & mask_q & {N_INT{ie_q}};
   assign hay_req = |req;

   // Priority encoder: the lowest-numbered active request wins
   always_comb begin
      // NOTE: default before the loop so every path assigns sel and no latch is inferred
      sel = '0;
      for (int i = N_INT - 1; i >= 0; i--) begin
         if (req[i]) sel = SEL_W'(i);
      end
   end

   assign lleno     = (occ_q == OCC_MAX);
   assign vacio     = (occ_q == '0);
   assign instr     = cpu_push | cpu_pop | reti;
   assign conflicto = cpu_push & cpu_pop;

   // An interrupt only fires in a cycle with no stack-touching instruction of its own
   assign take_int  = (estado_q == IDLE) & hay_req & ~instr & ~lleno;
   assign int_bloq  = (estado_q == IDLE) & hay_req & ~instr & lleno;

   // CALL passthrough is gated by reset so every output idles at zero while held in reset
   assign push_cpu  = reset & cpu_push & ~cpu_pop & ~lleno;
   assign push_bloq = cpu_push & ~cpu_pop & lleno;
   assign pop_cpu   = cpu_pop & ~cpu_push & ~vacio;
   assign pop_bloq  = cpu_pop & ~cpu_push & vacio;

   assign reti_sol  = (estado_q == SERVICIO) & reti & ~cpu_push & ~cpu_pop;
   assign reti_ok   = reti_sol & ~vacio;
   assign reti_bloq = reti_sol & vacio;

   assign clr = take_int ? (N_INT'(1) << sel) : '0;

   assign take        = take_int;
   assign vector      = take_int ? (VEC_BASE + WIDTH'(sel)) : '0;
   assign pop_ret     = reti_ok;
   assign push        = take_int | push_cpu;
   assign pop         = pop_cpu | reti_ok;
   assign weSP        = push | pop;
   assign entrada     = take_int ? pc_actual : (push_cpu ? cpu_dato : '0);
   assign pending     = pending_q;
   assign en_servicio = (estado_q == SERVICIO);
   assign err_pila    = err_q;

   // Next-state values for the FSM, enables, mask, requests, occupancy and error flag
   always_comb begin
      estado_d = estado_q;
      if (take_int) begin
         estado_d = SERVICIO;
      end else if (reti_ok) begin
         estado_d = IDLE;
      end

      ie_d      = ie_clr ? 1'b0 : (ie_set ? 1'b1 : ie_q);
      mask_d    = mask_we ? mask_in : mask_q;
      pending_d = (pending_q & ~clr) | flanco;

      occ_d = occ_q;
      if (push) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (pop) begin
         occ_d = occ_q - OCC_W'(1);
      end

      err_d = err_q | conflicto | int_bloq | push_bloq | pop_bloq | reti_bloq;
   end

   // Controller registers; all clear immediately on reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q  <= IDLE;
         ie_q      <= 1'b0;
         mask_q    <= '0;
         pending_q <= '0;
         occ_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         ie_q      <= ie_d;
         mask_q    <= mask_d;
         pending_q <= pending_d;
         occ_q     <= occ_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_ctrl_interrupciones.sv
// Self-checking bench for ctrl_interrupciones: a directed table, hand-written
// corner sequences and random stimulus, all compared against a queue-based model.
module tb_ctrl_interrupciones;

   localparam int         N_INT    = 4;
   localparam int         WIDTH    = 10;
   localparam int         DEPTH    = 2;
   localparam logic [9:0] VEC_BASE = 10'h3F0;

   typedef struct packed {
      logic [3:0] irq;
      logic       ie_set;
      logic       ie_clr;
      logic       mask_we;
      logic [3:0] mask_in;
      logic       reti;
      logic       cpu_push;
      logic       cpu_pop;
      logic [9:0] cpu_dato;
      logic [9:0] pc_actual;
   } in_t;

   typedef struct packed {
      logic       take;
      logic [9:0] vector;
      logic       pop_ret;
      logic       push;
      logic       pop;
      logic       wesp;
      logic [9:0] entrada;
      logic [3:0] pending;
      logic       en_servicio;
      logic       err_pila;
   } out_t;

   typedef struct {
      in_t  vi;
      out_t vo;
   } fila_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] irq = '0;
   logic       ie_set = 1'b0, ie_clr = 1'b0, mask_we = 1'b0;
   logic [3:0] mask_in = '0;
   logic       reti = 1'b0, cpu_push = 1'b0, cpu_pop = 1'b0;
   logic [9:0] cpu_dato = '0, pc_actual = '0;
   logic       take, pop_ret, push, pop, weSP, en_servicio, err_pila;
   logic [9:0] vector, entrada;
   logic [3:0] pending;

   ctrl_interrupciones #(
      .N_INT    (N_INT),
      .WIDTH    (WIDTH),
      .VEC_BASE (VEC_BASE),
      .DEPTH    (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .irq         (irq),
      .ie_set      (ie_set),
      .ie_clr      (ie_clr),
      .mask_we     (mask_we),
      .mask_in     (mask_in),
      .reti        (reti),
      .cpu_push    (cpu_push),
      .cpu_pop     (cpu_pop),
      .cpu_dato    (cpu_dato),
      .pc_actual   (pc_actual),
      .take        (take),
      .vector      (vector),
      .pop_ret     (pop_ret),
      .push        (push),
      .pop         (pop),
      .weSP        (weSP),
      .entrada     (entrada),
      .pending     (pending),
      .en_servicio (en_servicio),
      .err_pila    (err_pila)
   );

   always #5 clk = ~clk;

   int   n_vec = 0;
   int   n_err = 0;
   in_t  x;
   out_t act;

   // Reference model: request bits, enables, a queue standing in for the stack,
   // and a short history of sampled irq levels for the synchroniser latency.
   logic [3:0] m_pend, m_mask;
   logic       m_ie, m_serv, m_err;
   logic [9:0] m_pila[$];
   logic [3:0] m_hist[$];

   task automatic check(input string nombre, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nombre, got, exp, $time);
      end
   endtask

   task automatic drive(input in_t v);
      irq       = v.irq;
      ie_set    = v.ie_set;
      ie_clr    = v.ie_clr;
      mask_we   = v.mask_we;
      mask_in   = v.mask_in;
      reti      = v.reti;
      cpu_push  = v.cpu_push;
      cpu_pop   = v.cpu_pop;
      cpu_dato  = v.cpu_dato;
      pc_actual = v.pc_actual;
   endtask

   task automatic sample_out();
      act.take        = take;
      act.vector      = vector;
      act.pop_ret     = pop_ret;
      act.push        = push;
      act.pop         = pop;
      act.wesp        = weSP;
      act.entrada     = entrada;
      act.pending     = pending;
      act.en_servicio = en_servicio;
      act.err_pila    = err_pila;
   endtask

   task automatic model_reset();
      m_pend = '0;
      m_mask = '0;
      m_ie   = 1'b0;
      m_serv = 1'b0;
      m_err  = 1'b0;
      m_pila.delete();
      m_hist.delete();
      for (int i = 0; i < 3; i++) m_hist.push_back(4'h0);
   endtask

   function automatic out_t model_out(input in_t v);
      out_t       o;
      logic [3:0] req;
      int         sel;
      o = '0;
      o.pending     = m_pend;
      o.en_servicio = m_serv;
      o.err_pila    = m_err;
      req = m_pend & m_mask & {4{m_ie}};
      sel = 0;
      for (int i = 3; i >= 0; i--) if (req[i]) sel = i;
      if (!m_serv && req != 0 && !(v.cpu_push || v.cpu_pop || v.reti) && m_pila.size() < DEPTH) begin
         o.take    = 1'b1;
         o.vector  = VEC_BASE + 10'(sel);
         o.push    = 1'b1;
         o.wesp    = 1'b1;
         o.entrada = v.pc_actual;
      end
      if (v.cpu_push && !v.cpu_pop && m_pila.size() < DEPTH) begin
         o.push    = 1'b1;
         o.wesp    = 1'b1;
         o.entrada = v.cpu_dato;
      end
      if (v.cpu_pop && !v.cpu_push && m_pila.size() > 0) begin
         o.pop  = 1'b1;
         o.wesp = 1'b1;
      end
      if (m_serv && v.reti && !v.cpu_push && !v.cpu_pop && m_pila.size() > 0) begin
         o.pop_ret = 1'b1;
         o.pop     = 1'b1;
         o.wesp    = 1'b1;
      end
      return o;
   endfunction

   task automatic model_update(input in_t v);
      out_t       o;
      logic [3:0] req;
      logic       lleno, vacio, instr;
      o     = model_out(v);
      lleno = (m_pila.size() >= DEPTH);
      vacio = (m_pila.size() == 0);
      instr = v.cpu_push | v.cpu_pop | v.reti;
      req   = m_pend & m_mask & {4{m_ie}};
      if (v.cpu_push && v.cpu_pop) m_err = 1'b1;
      if (v.cpu_push && !v.cpu_pop && lleno) m_err = 1'b1;
      if (v.cpu_pop && !v.cpu_push && vacio) m_err = 1'b1;
      if (m_serv && v.reti && !v.cpu_push && !v.cpu_pop && vacio) m_err = 1'b1;
      if (!m_serv && req != 0 && !instr && lleno) m_err = 1'b1;
      if (o.push) m_pila.push_back(o.entrada);
      if (o.pop) void'(m_pila.pop_back());
      if (o.take) begin
         m_pend[int'(o.vector - VEC_BASE)] = 1'b0;
         m_serv = 1'b1;
      end
      if (o.pop_ret) m_serv = 1'b0;
      if (v.ie_clr) m_ie = 1'b0;
      else if (v.ie_set) m_ie = 1'b1;
      if (v.mask_we) m_mask = v.mask_in;
      m_hist.push_back(v.irq);
      if (m_hist.size() > 4) void'(m_hist.pop_front());
      m_pend = m_pend | (m_hist[1] & ~m_hist[0]);
   endtask

   // One clock cycle: drive at the falling edge, compare just after, advance the model.
   task automatic step(input in_t v, input string nombre);
      @(negedge clk);
      drive(v);
      #1;
      sample_out();
      check(nombre, 32'(act), 32'(model_out(v)));
      model_update(v);
   endtask

   task automatic do_reset();
      in_t z;
      z = '0;
      @(negedge clk);
      drive(z);
      #2;
      reset = 1'b0;
      #1;
      sample_out();
      check("reset_async", 32'(act), 32'h0);
      @(negedge clk);
      #2;
      reset = 1'b1;
      model_reset();
      model_update(z);
   endtask

   function automatic in_t vin(logic [3:0] irq_v, logic ies, logic iec, logic mwe,
                               logic [3:0] msk, logic rt, logic cpush, logic cpop,
                               logic [9:0] dato, logic [9:0] pc);
      in_t v;
      v.irq = irq_v;  v.ie_set = ies;     v.ie_clr = iec;   v.mask_we = mwe;
      v.mask_in = msk; v.reti = rt;       v.cpu_push = cpush; v.cpu_pop = cpop;
      v.cpu_dato = dato; v.pc_actual = pc;
      return v;
   endfunction

   function automatic out_t vout(logic tk, logic [9:0] vec, logic pr, logic ps, logic pp,
                                 logic we, logic [9:0] ent, logic [3:0] pend, logic serv,
                                 logic err);
      out_t o;
      o.take = tk;    o.vector = vec;   o.pop_ret = pr;  o.push = ps;
      o.pop = pp;     o.wesp = we;      o.entrada = ent; o.pending = pend;
      o.en_servicio = serv; o.err_pila = err;
      return o;
   endfunction

   fila_t      tabla[18];
   logic [3:0] irq_r;
   int         r;

   initial begin
      model_reset();

      // Directed table, starting from reset with ie=0, mask=0, empty stack
      tabla[0]  = '{vin(4'h0,0,0,0,4'h0,0,0,0,10'h000,10'h000), vout(0,10'h000,0,0,0,0,10'h000,4'h0,0,0)};
      tabla[1]  = '{vin(4'h0,0,0,0,4'h0,1,0,0,10'h000,10'h000), vout(0,10'h000,0,0,0,0,10'h000,4'h0,0,0)};
      tabla[2]  = '{vin(4'h0,0,0,0,4'h0,0,0,0,10'h000,10'h000), vout(0,10'h000,0,0,0,0,10'h000,4'h0,0,0)};
      tabla[3]  = '{vin(4'h0,0,0,0,4'h0,0,0,1,10'h000,10'h000), vout(0,10'h000,0,0,0,0,10'h000,4'h0,0,0)};
      tabla[4]  = '{vin(4'h0,0,0,0,4'h0,0,0,0,10'h000,10'h000), vout(0,10'h000,0,0,0,0,10'h000,4'h0,0,1)};
      tabla[5]  = '{vin(4'h0,0,0,0,4'h0,0,1,0,10'h155,10'h000), vout(0,10'h000,0,1,0,1,10'h155,4'h0,0,1)};
      tabla[6]  = '{vin(4'h0,0,0,0,4'h0,0,1,1,10'h0AA,10'h000), vout(0,10'h000,0,0,0,0,10'h000,4'h0,0,1)};
      tabla[7]  = '{vin(4'h0,0,0,0,4'h0,0,0,1,10'h000,10'h000), vout(0,10'h000,0,0,1,1,10'h000,4'h0,0,1)};
      tabla[8]  = '{vin(4'hF,1,0,1,4'h5,0,0,0,10'h000,10'h000), vout(0,10'h000,0,0,0,0,10'h000,4'h0,0,1)};
      tabla[9]  = '{vin(4'hF,0,0,0,4'h0,0,0,0,10'h000,10'h000), vout(0,10'h000,0,0,0,0,10'h000,4'h0,0,1)};
      tabla[10] = '{vin(4'hF,0,0,0,4'h0,0,0,0,10'h000,10'h000), vout(0,10'h000,0,0,0,0,10'h000,4'h0,0,1)};
      tabla[11] = '{vin(4'hF,0,0,0,4'h0,0,0,0,10'h000,10'h012), vout(1,10'h3F0,0,1,0,1,10'h012,4'hF,0,1)};
      tabla[12] = '{vin(4'h0,0,0,0,4'h0,0,0,0,10'h000,10'h000), vout(0,10'h000,0,0,0,0,10'h000,4'hE,1,1)};
      tabla[13] = '{vin(4'h0,0,0,0,4'h0,1,0,0,10'h000,10'h000), vout(0,10'h000,1,0,1,1,10'h000,4'hE,1,1)};
      tabla[14] = '{vin(4'h0,0,0,0,4'h0,0,0,0,10'h000,10'h020), vout(1,10'h3F2,0,1,0,1,10'h020,4'hE,0,1)};
      tabla[15] = '{vin(4'h0,0,1,0,4'h0,0,0,0,10'h000,10'h000), vout(0,10'h000,0,0,0,0,10'h000,4'hA,1,1)};
      tabla[16] = '{vin(4'h0,0,0,0,4'h0,1,0,0,10'h000,10'h000), vout(0,10'h000,1,0,1,1,10'h000,4'hA,1,1)};
      tabla[17] = '{vin(4'h0,0,0,0,4'h0,0,0,0,10'h000,10'h000), vout(0,10'h000,0,0,0,0,10'h000,4'hA,0,1)};

      do_reset();
      for (int i = 0; i < 18; i++) begin
         step(tabla[i].vi, $sformatf("tabla_model_%0d", i));
         check($sformatf("tabla_%0d", i), 32'(act), 32'(tabla[i].vo));
      end

      // Single request: vector, saved PC, then RETI
      do_reset();
      x = '0; x.ie_set = 1'b1; x.mask_we = 1'b1; x.mask_in = 4'hF;
      step(x, "t2_cfg");
      x = '0; x.irq = 4'b0100; x.pc_actual = 10'h045;
      step(x, "t2_w1");
      step(x, "t2_w2");
      step(x, "t2_w3");
      check("t2_pend_latency", 32'(act.pending), 32'h0);
      step(x, "t2_take");
      check("t2_take", 32'(act.take), 32'h1);
      check("t2_vector", 32'(act.vector), 32'h3F2);
      check("t2_push", 32'(act.push), 32'h1);
      check("t2_entrada", 32'(act.entrada), 32'h045);
      x.irq = 4'h0;
      step(x, "t2_serv");
      check("t2_en_servicio", 32'(act.en_servicio), 32'h1);
      x = '0; x.reti = 1'b1;
      step(x, "t2_reti");
      check("t2_pop_ret", 32'(act.pop_ret), 32'h1);
      check("t2_pop", 32'(act.pop), 32'h1);
      x = '0;
      step(x, "t2_idle");
      check("t2_back_idle", 32'(act.en_servicio), 32'h0);

      // Simultaneous lines 1 and 3: line 1 first, line 3 right after RETI
      x = '0; x.irq = 4'b1010; x.pc_actual = 10'h060;
      step(x, "t3_w1");
      step(x, "t3_w2");
      step(x, "t3_w3");
      step(x, "t3_take1");
      check("t3_vector1", 32'(act.vector), 32'h3F1);
      x.irq = 4'h0;
      step(x, "t3_serv");
      check("t3_pend_left", 32'(act.pending), 32'h8);
      check("t3_no_nest", 32'(act.take), 32'h0);
      x = '0; x.reti = 1'b1;
      step(x, "t3_reti");
      x = '0; x.pc_actual = 10'h061;
      step(x, "t3_take3");
      check("t3_vector3", 32'(act.vector), 32'h3F3);
      check("t3_entrada3", 32'(act.entrada), 32'h061);
      x = '0; x.reti = 1'b1;
      step(x, "t3_reti2");
      x = '0;
      step(x, "t3_idle");

      // Request deferred by a CALL in the same cycle
      x = '0; x.irq = 4'b0001; x.pc_actual = 10'h050;
      step(x, "t4_w1");
      step(x, "t4_w2");
      step(x, "t4_w3");
      x.cpu_push = 1'b1; x.cpu_dato = 10'h200;
      step(x, "t4_call");
      check("t4_no_take", 32'(act.take), 32'h0);
      check("t4_call_data", 32'(act.entrada), 32'h200);
      x = '0; x.pc_actual = 10'h051;
      step(x, "t4_take");
      check("t4_take", 32'(act.take), 32'h1);
      check("t4_entrada", 32'(act.entrada), 32'h051);
      x = '0; x.reti = 1'b1;
      step(x, "t4_reti");
      x = '0; x.cpu_pop = 1'b1;
      step(x, "t4_ret");
      x = '0;
      step(x, "t4_idle");

      // Full stack blocks the interrupt until a RET frees a slot
      do_reset();
      x = '0; x.ie_set = 1'b1; x.mask_we = 1'b1; x.mask_in = 4'hF;
      step(x, "t5_cfg");
      x = '0; x.cpu_push = 1'b1; x.cpu_dato = 10'h100;
      step(x, "t5_call1");
      x.cpu_dato = 10'h101;
      step(x, "t5_call2");
      x = '0; x.irq = 4'b0001; x.pc_actual = 10'h070;
      step(x, "t5_w1");
      step(x, "t5_w2");
      step(x, "t5_w3");
      step(x, "t5_blocked");
      check("t5_no_take", 32'(act.take), 32'h0);
      check("t5_err_before", 32'(act.err_pila), 32'h0);
      x.irq = 4'h0;
      step(x, "t5_err");
      check("t5_err_set", 32'(act.err_pila), 32'h1);
      check("t5_still_pending", 32'(act.pending), 32'h1);
      x = '0; x.cpu_pop = 1'b1;
      step(x, "t5_ret");
      check("t5_ret_pop", 32'(act.pop), 32'h1);
      x = '0; x.pc_actual = 10'h071;
      step(x, "t5_take");
      check("t5_take", 32'(act.take), 32'h1);
      check("t5_vector", 32'(act.vector), 32'h3F0);

      // Reset while a handler runs with lines 1 and 2 pending
      x = '0; x.irq = 4'b0110;
      step(x, "t1_w1");
      step(x, "t1_w2");
      step(x, "t1_w3");
      step(x, "t1_w4");
      check("t1_pending", 32'(act.pending), 32'h6);
      check("t1_in_handler", 32'(act.en_servicio), 32'h1);
      do_reset();
      x = '0;
      step(x, "t1_after");
      check("t1_idle", 32'(act.en_servicio), 32'h0);

      // Random traffic against the model
      irq_r = '0;
      for (int k = 0; k < 1500; k++) begin
         if (k == 750) do_reset();
         for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 7) == 0) irq_r[i] = ~irq_r[i];
         end
         x = '0;
         x.irq       = irq_r;
         x.pc_actual = 10'($urandom);
         x.cpu_dato  = 10'($urandom);
         r = int'($urandom_range(0, 15));
         case (r)
            0, 1:    x.cpu_push = 1'b1;
            2, 3:    x.cpu_pop = 1'b1;
            4:       begin x.cpu_push = 1'b1; x.cpu_pop = 1'b1; end
            5, 6, 7: x.reti = 1'b1;
            default: ;
         endcase
         if ($urandom_range(0, 7) == 0) x.ie_set = 1'b1;
         if ($urandom_range(0, 23) == 0) x.ie_clr = 1'b1;
         if ($urandom_range(0, 15) == 0) begin
            x.mask_we = 1'b1;
            x.mask_in = 4'($urandom);
         end
         step(x, "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
